text_fetch: RTL and testbench

TEXT_FETCH -- requirements
Module: text_fetch

---
 rtl/text_fetch_pkg.sv | 21 ++
 rtl/text_fetch_sync_fifo.sv | 71 +++++++
 rtl/text_fetch.sv | 109 ++++++++++
 tb/tb_text_fetch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/text_fetch_pkg.sv
// Shared video constants for the text fetch path: default geometry, FIFO depth
// and the fetch FSM state encoding.
package text_fetch_pkg;

   localparam int unsigned   NDefault     = 16;
   localparam logic [15:0]   BaseDefault  = 16'h4000;
   localparam int unsigned   CellsDefault = 2400;
   localparam int unsigned   DepthDefault = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StDone  = 2'd2
   } fetch_state_e;

   // Occupancy counter must hold the value DEPTH itself, hence one extra bit.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/text_fetch_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a synchronous clear; pointers
// wrap modulo DEPTH and occupancy is tracked in a separate counter.
module sync_fifo
   import text_fetch_pkg::*;
#(
   parameter int unsigned N     = NDefault,
   parameter int unsigned DEPTH = DepthDefault
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          push,
   input  logic                          pop,
   input  logic [N-1:0]                  din,
   output logic [N-1:0]                  dout,
   output logic                          empty,
   output logic                          full,
   output logic [cnt_width(DEPTH)-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);
   localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

   logic [N-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == DepthCnt);
   assign count   = count_q;
   assign dout    = mem_q[rptr_q];

   // Clear wins over any concurrent push or pop.
   assign push_ok = push && !full && !clear;
   assign pop_ok  = pop && !empty && !clear;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clear) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + PW'(1);
         if (pop_ok)  rptr_d = rptr_q + PW'(1);
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= din;
   end

endmodule

// File: rtl/text_fetch.sv
// Prefetches one frame of text cells from the RAM second read port into a
// small FIFO and presents them to the character generator with valid/ready.
module text_fetch
   import text_fetch_pkg::*;
#(
   parameter int unsigned   N     = NDefault,
   parameter logic [N-1:0]  BASE  = BaseDefault,
   parameter int unsigned   CELLS = CellsDefault,
   parameter int unsigned   DEPTH = DepthDefault
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         frame_start,
   output logic [N-1:0] addr2,
   output logic         rd2,
   input  logic [N-1:0] data2,
   output logic         cell_valid,
   output logic [N-1:0] cell_data,
   input  logic         cell_ready
);

   localparam int unsigned   IW       = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int unsigned   CW       = cnt_width(DEPTH);
   localparam logic [IW-1:0] LastIdx  = IW'(CELLS - 1);
   localparam logic [CW:0]   DepthOcc = (CW + 1)'(DEPTH);

   fetch_state_e  state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          inflight_q, inflight_d;

   logic          fifo_push, fifo_pop;
   logic          fifo_empty, fifo_full;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occupancy;
   logic          room;

   // A read is only issued when its return is guaranteed a FIFO slot.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
   assign room      = !fifo_full && (occupancy < DepthOcc);

   // Index parks at the last cell, so addr2 holds its value outside FETCH.
   assign addr2 = BASE + N'(idx_q);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rd2     = 1'b0;

      unique case (state_q)
         StIdle: ;
         StFetch: begin
            if (room) begin
               rd2 = 1'b1;
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         StDone: ;
         default: state_d = StIdle;
      endcase

      // A new frame overrides everything; no read is issued in the pulse cycle.
      if (frame_start) begin
         rd2     = 1'b0;
         state_d = StFetch;
         idx_d   = '0;
      end
   end

   assign inflight_d = rd2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         inflight_q <= inflight_d;
      end
   end

   // Only a return that follows a read strobe is captured; a frame restart
   // drops the stale one.
   assign fifo_push  = inflight_q && !frame_start;
   assign fifo_pop   = cell_ready;
   assign cell_valid = !fifo_empty;

   sync_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (frame_start),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (data2),
      .dout  (cell_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_text_fetch.sv
// Randomized bench for text_fetch: a queue-based model predicts every cycle's
// read strobe, address and FIFO head; directed phases pin key literal values.
module tb_text_fetch;

   localparam int unsigned CELLS = 2400;
   localparam int unsigned DEPTH = 8;
   localparam logic [15:0] BASE  = 16'h4000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic        cell_ready = 1'b0;
   logic        rd2, cell_valid;
   logic [15:0] addr2, data2, cell_data;

   int          total = 0;
   int          bad = 0;
   logic [15:0] salt = 16'h0;
   int          rdy_mode = 0;

   // Model state: cells the FIFO must hold, pending return, frame progress.
   logic [15:0] mq[$];
   bit          pend = 1'b0;
   logic [15:0] pend_addr = 16'h0;
   bit          active = 1'b0;
   int          next_idx = 0;
   int          delivered = 0;
   int          rd_count = 0;
   logic [15:0] first_cell = 16'h0;
   logic [15:0] last_cell = 16'h0;
   logic [15:0] last_addr = 16'h0;

   text_fetch dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .addr2       (addr2),
      .rd2         (rd2),
      .data2       (data2),
      .cell_valid  (cell_valid),
      .cell_data   (cell_data),
      .cell_ready  (cell_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ram(input logic [15:0] a);
      return (a - BASE) ^ salt;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // RAM port: data one cycle after the strobe, garbage on every other cycle.
   always @(posedge clk) data2 <= rd2 ? ram(addr2) : 16'($urandom);

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       cell_ready = 1'b1;
         1:       cell_ready = 1'b0;
         2:       cell_ready = ~cell_ready;
         default: cell_ready = 1'($urandom_range(0, 1));
      endcase
   end

   always @(negedge clk) begin
      bit          exp_rd2;
      logic [15:0] head;
      if (reset) begin
         chk("rst_rd2", {31'b0, rd2}, 32'd0);
         chk("rst_valid", {31'b0, cell_valid}, 32'd0);
         mq.delete();
         pend      = 1'b0;
         active    = 1'b0;
         next_idx  = 0;
         delivered = 0;
         rd_count  = 0;
      end else begin
         exp_rd2 = active && !frame_start && (mq.size() + int'(pend) < DEPTH);
         chk("cell_valid", {31'b0, cell_valid}, {31'b0, mq.size() != 0});
         if (mq.size() != 0) begin
            chk("cell_data", {16'b0, cell_data}, {16'b0, mq[0]});
            chk("cell_known", {31'b0, $isunknown(cell_data)}, 32'd0);
         end
         chk("rd2", {31'b0, rd2}, {31'b0, exp_rd2});
         if (rd2 && exp_rd2) chk("addr2", {16'b0, addr2}, 32'(BASE) + 32'(next_idx));

         if (frame_start) begin
            mq.delete();
            pend      = 1'b0;
            active    = 1'b1;
            next_idx  = 0;
            delivered = 0;
            rd_count  = 0;
         end else begin
            if (cell_ready && mq.size() != 0) begin
               head = mq.pop_front();
               if (delivered == 0) first_cell = head;
               last_cell = head;
               delivered++;
            end
            if (pend) mq.push_back(ram(pend_addr));
            pend = exp_rd2;
            if (exp_rd2) begin
               pend_addr = BASE + 16'(next_idx);
               last_addr = pend_addr;
               rd_count++;
               next_idx++;
               if (next_idx == CELLS) active = 1'b0;
            end
         end
      end
   end

   task automatic pulse_frame();
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
   endtask

   task automatic wait_deliv(input int n, input int budget);
      int c = 0;
      while (delivered < n && c < budget) begin
         @(negedge clk); #1;
         c++;
      end
      total++;
      if (delivered < n) begin
         bad++;
         $display("FAIL wait_deliv: delivered %0d required %0d", delivered, n);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk); #1;
      chk("reset_addr2", {16'b0, addr2}, 32'h4000);
      chk("reset_rd2", {31'b0, rd2}, 32'd0);
      chk("reset_valid", {31'b0, cell_valid}, 32'd0);

      // Full frame streaming, RAM[BASE+i] = i.
      salt = 16'h0;
      rdy_mode = 0;
      pulse_frame();
      wait_deliv(CELLS, 8000);
      chk("stream_first", {16'b0, first_cell}, 32'd0);
      chk("stream_last", {16'b0, last_cell}, 32'd2399);
      chk("stream_reads", rd_count, CELLS);
      repeat (20) @(negedge clk);
      #1;
      chk("done_reads", rd_count, CELLS);
      chk("done_rd2", {31'b0, rd2}, 32'd0);
      chk("done_valid", {31'b0, cell_valid}, 32'd0);

      // Backpressure: consumer stalled from the frame start.
      salt = 16'($urandom);
      rdy_mode = 1;
      pulse_frame();
      repeat (30) @(negedge clk);
      #1;
      chk("bp_reads", rd_count, 8);
      chk("bp_last_addr", {16'b0, last_addr}, 32'h4007);
      chk("bp_valid", {31'b0, cell_valid}, 32'd1);
      chk("bp_rd2", {31'b0, rd2}, 32'd0);
      chk("bp_head", {16'b0, cell_data}, {16'b0, salt});

      // Toggling ready exercises simultaneous push and pop.
      rdy_mode = 2;
      wait_deliv(CELLS, 12000);
      chk("toggle_reads", rd_count, CELLS);

      // Restart mid-frame with random ready.
      rdy_mode = 3;
      pulse_frame();
      wait_deliv(100, 2000);
      pulse_frame();
      @(negedge clk); #1;
      chk("restart_empty", {31'b0, cell_valid}, 32'd0);
      chk("restart_rd2", {31'b0, rd2}, 32'd1);
      chk("restart_addr", {16'b0, addr2}, 32'h4000);
      wait_deliv(CELLS, 12000);
      chk("restart_first", {16'b0, first_cell}, {16'b0, salt});

      // Reset in the middle of a frame.
      salt = 16'($urandom);
      rdy_mode = 0;
      pulse_frame();
      wait_deliv(50, 2000);
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      chk("rstmid_reads", rd_count, 0);
      chk("rstmid_valid", {31'b0, cell_valid}, 32'd0);
      chk("rstmid_rd2", {31'b0, rd2}, 32'd0);
      rdy_mode = 3;
      pulse_frame();
      wait_deliv(1, 100);
      chk("rstmid_first", {16'b0, first_cell}, {16'b0, salt});
      wait_deliv(CELLS, 12000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
